// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC datapath (multiply stage and accumulator).
//   MAC_M / MAC_N : default operand widths
//   prod_width()  : full-width unsigned product width for an M x N multiply
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int MAC_M = 6;
    localparam int MAC_N = 4;

    // An unsigned M x N product never needs more than M+N bits.
    function automatic int prod_width(input int m, input int n);
        return m + n;
    endfunction

endpackage

// File: rtl/mult_pp_row.sv
// ---------------------------------------------------------------------------
// mult_pp_row
// One row of the partial-product summation: a W-bit ripple-carry adder.
//   i_a   [W-1:0] : running sum of the rows above
//   i_b   [W-1:0] : shifted, masked partial product for this row
//   o_sum [W:0]   : i_a + i_b, carry out in the MSB
// ---------------------------------------------------------------------------
module mult_pp_row #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W:0]   o_sum
);

    logic [W:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar j = 0; j < W; j++) begin : g_fa
        logic w_p;
        assign w_p        = i_a[j] ^ i_b[j];
        assign o_sum[j]   = w_p ^ w_c[j];
        assign w_c[j+1]   = (i_a[j] & i_b[j]) | (w_c[j] & w_p);
    end

    assign o_sum[W] = w_c[W];

endmodule

// File: rtl/multiplier_m_n_bits.sv
// ---------------------------------------------------------------------------
// multiplier_m_n_bits
// Unsigned M x N multiplier, multiply stage of the MAC unit. The product is
// formed combinationally by an explicit partial-product array and registered
// once (latency 1, one product per clock, no backpressure).
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : num1/num2 valid this cycle
//   num1 [M]  : unsigned multiplicand
//   num2 [N]  : unsigned multiplier
//   Result    : registered num1*num2, M+N bits
//   out_valid : Result holds a new product this cycle
// ---------------------------------------------------------------------------
module multiplier_m_n_bits
    import mac_pkg::*;
#(
    parameter int M = MAC_M,
    parameter int N = MAC_N
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [M-1:0]                num1,
    input  logic [N-1:0]                num2,
    output logic [prod_width(M,N)-1:0]  Result,
    output logic                        out_valid
);

    localparam int PW = prod_width(M, N);

    logic [PW-1:0] r_result;
    logic          r_valid;
    logic [PW-1:0] w_product;

    // Row i sums rows 0..i. Row 0 is the bare partial product (M bits);
    // row i>=1 adds (num1 & num2[i]) << i onto the previous M+i-bit sum,
    // giving M+i+1 bits, so the last row is exactly M+N bits wide.
    for (genvar i = 0; i < N; i++) begin : g_row
        localparam int SW = (i == 0) ? M : M + i + 1;
        logic [SW-1:0] w_s;
        logic [M-1:0]  w_pp;

        assign w_pp = num1 & {M{num2[i]}};

        if (i == 0) begin : g_pass
            assign w_s = w_pp;
        end else begin : g_add
            logic [M+i-1:0] w_shift;
            assign w_shift = {w_pp, {i{1'b0}}};
            mult_pp_row #(.W(M + i)) u_row (
                .i_a   (g_row[i-1].w_s),
                .i_b   (w_shift),
                .o_sum (w_s)
            );
        end
    end

    // With a single row there is no adder, so the top product bit is zero.
    if (N == 1) begin : g_one_row
        assign w_product = {1'b0, g_row[0].w_s};
    end else begin : g_multi_row
        assign w_product = g_row[N-1].w_s;
    end

    // Result holds on idle cycles; only the valid strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_product;
            end
        end
    end

    assign Result    = r_result;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_multiplier_m_n_bits.sv
module tb_multiplier_m_n_bits;

    logic        clk;
    logic        rst_n;

    // default 6x4 instance
    logic        in_valid;
    logic [5:0]  num1;
    logic [3:0]  num2;
    logic [9:0]  result;
    logic        out_valid;

    // 1x1 instance
    logic        v11;
    logic [0:0]  a11;
    logic [0:0]  b11;
    logic [1:0]  r11;
    logic        ov11;

    // 8x8 instance
    logic        v88;
    logic [7:0]  a88;
    logic [7:0]  b88;
    logic [15:0] r88;
    logic        ov88;

    // 3x7 instance
    logic        v37;
    logic [2:0]  a37;
    logic [6:0]  b37;
    logic [9:0]  r37;
    logic        ov37;

    int n_tests = 0;
    int n_fail  = 0;

    multiplier_m_n_bits #(.M(6), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num1(num1), .num2(num2),
        .Result(result), .out_valid(out_valid));

    multiplier_m_n_bits #(.M(1), .N(1)) dut11 (
        .clk(clk), .rst_n(rst_n), .in_valid(v11), .num1(a11), .num2(b11),
        .Result(r11), .out_valid(ov11));

    multiplier_m_n_bits #(.M(8), .N(8)) dut88 (
        .clk(clk), .rst_n(rst_n), .in_valid(v88), .num1(a88), .num2(b88),
        .Result(r88), .out_valid(ov88));

    multiplier_m_n_bits #(.M(3), .N(7)) dut37 (
        .clk(clk), .rst_n(rst_n), .in_valid(v37), .num1(a37), .num2(b37),
        .Result(r37), .out_valid(ov37));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic [3:0] b);
        @(negedge clk);
        in_valid = v;
        num1     = a;
        num2     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0]  seq_a [6];
        logic [3:0]  seq_b [6];
        logic [9:0]  seq_r [6];
        logic [15:0] e88;
        logic [9:0]  e37;

        // 31 on a 4-bit multiplier keeps only its low bits: 15
        seq_a = '{6'd63, 6'd0, 6'd27, 6'd12, 6'd20, 6'd32};
        seq_b = '{4'd15, 4'd3, 4'd9, 4'(31), 4'd0, 4'd7};
        seq_r = '{10'd945, 10'd0, 10'd243, 10'd180, 10'd0, 10'd224};

        v11 = 0; a11 = 0; b11 = 0;
        v88 = 0; a88 = 0; b88 = 0;
        v37 = 0; a37 = 0; b37 = 0;

        // reset held with valid operands present
        rst_n    = 1'b0;
        in_valid = 1'b1;
        num1     = 6'd63;
        num2     = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_valid",  64'(out_valid), 64'd0);

        // first edge after release captures
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_result", 64'(result), 64'd945);
        chk("release_valid",  64'(out_valid), 64'd1);

        // back-to-back directed products
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, seq_a[k], seq_b[k]);
            chk($sformatf("seq%0d_result", k), 64'(result), 64'(seq_r[k]));
            chk($sformatf("seq%0d_valid", k),  64'(out_valid), 64'd1);
        end

        // hold: idle cycles keep the last product
        drive(1'b1, 6'd27, 4'd9);
        chk("pre_hold_result", 64'(result), 64'd243);
        drive(1'b0, 6'd5, 4'd5);
        chk("hold_result", 64'(result), 64'd243);
        chk("hold_valid",  64'(out_valid), 64'd0);
        drive(1'b0, 6'd5, 4'd5);
        chk("hold2_result", 64'(result), 64'd243);

        // asynchronous reset between edges
        drive(1'b1, 6'd32, 4'd7);
        chk("pre_rst_result", 64'(result), 64'd224);
        @(negedge clk);
        in_valid = 1'b1;
        num1     = 6'd63;
        num2     = 4'd15;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_result", 64'(result), 64'd0);
        chk("async_rst_valid",  64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_held_result", 64'(result), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_result", 64'(result), 64'd0);
        chk("post_rst_valid",  64'(out_valid), 64'd0);

        // exhaustive 64 x 16
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(1'b1, 6'(a), 4'(b));
                chk($sformatf("exh_%0dx%0d", a, b), 64'(result), 64'(a * b));
                chk($sformatf("exh_v_%0dx%0d", a, b), 64'(out_valid), 64'd1);
            end
        end

        // parameter sweep: directed corners then random
        @(negedge clk);
        in_valid = 1'b0;
        v11 = 1; a11 = 1'b1; b11 = 1'b1;
        v88 = 1; a88 = 8'd255; b88 = 8'd255;
        v37 = 1; a37 = 3'd7; b37 = 7'd127;
        @(posedge clk);
        #1;
        chk("p11_one",  64'(r11), 64'd1);
        chk("p11_v",    64'(ov11), 64'd1);
        chk("p88_max",  64'(r88), 64'd65025);
        chk("p37_max",  64'(r37), 64'd889);

        @(negedge clk);
        a11 = 1'b1; b11 = 1'b0;
        @(posedge clk);
        #1;
        chk("p11_zero", 64'(r11), 64'd0);

        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            a88 = 8'($urandom_range(0, 255));
            b88 = 8'($urandom_range(0, 255));
            a37 = 3'($urandom_range(0, 7));
            b37 = 7'($urandom_range(0, 127));
            a11 = 1'($urandom_range(0, 1));
            b11 = 1'($urandom_range(0, 1));
            e88 = 16'(int'(a88) * int'(b88));
            e37 = 10'(int'(a37) * int'(b37));
            @(posedge clk);
            #1;
            chk($sformatf("p88_rnd%0d", k), 64'(r88), 64'(e88));
            chk($sformatf("p37_rnd%0d", k), 64'(r37), 64'(e37));
            chk($sformatf("p11_rnd%0d", k), 64'(r11), 64'(a11 & b11));
            chk($sformatf("p88_v%0d", k),   64'(ov88), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
